// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input from the UART receiver and the FIFO/trigger outputs
// toward the SDRAM write path, bundled for the command parser.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       po_flag;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;
  logic       wr_trig;
  logic       rd_trig;
  logic       frame_err;

  modport master (
    output rx_data, po_flag,
    input  wfifo_wr_en, wfifo_wr_data, wr_trig, rd_trig, frame_err
  );

  modport slave (
    input  rx_data, po_flag,
    output wfifo_wr_en, wfifo_wr_data, wr_trig, rd_trig, frame_err
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses HEADER/command/payload frames from a UART byte stream into FIFO
// pushes and SDRAM write/read trigger pulses, with an inter-byte timeout.
//
// state  | meaning
// S_IDLE | waiting for HEADER; other bytes are dropped silently
// S_CMD  | HEADER seen, next byte selects write, read or error
// S_DATA | forwarding WR_LEN payload bytes to the write FIFO
module uart_cmd_parser #(
  parameter logic [7:0] HEADER  = 8'h55,
  parameter logic [7:0] CMD_WR  = 8'hAA,
  parameter logic [7:0] CMD_RD  = 8'hBB,
  parameter int         WR_LEN  = 4,
  parameter int         TIMEOUT = 50000
) (
  input logic              clk,
  input logic              rst_n,
  uart_cmd_parser_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    WR_LAST  = 8'(WR_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          wr_pend_q, wr_pend_d;
  logic          wfifo_wr_en_q, wfifo_wr_en_d;
  logic [7:0]    wfifo_wr_data_q, wfifo_wr_data_d;
  logic          wr_trig_q, wr_trig_d;
  logic          rd_trig_q, rd_trig_d;
  logic          frame_err_q, frame_err_d;
  logic          tmo_hit;

  // A byte arriving in the expiry cycle takes priority over the abort.
  assign tmo_hit = (tmo_cnt_q == TMO_LAST) && !bus.po_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      byte_cnt_q      <= 8'h00;
      tmo_cnt_q       <= '0;
      wr_pend_q       <= 1'b0;
      wfifo_wr_en_q   <= 1'b0;
      wfifo_wr_data_q <= 8'h00;
      wr_trig_q       <= 1'b0;
      rd_trig_q       <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      wr_pend_q       <= wr_pend_d;
      wfifo_wr_en_q   <= wfifo_wr_en_d;
      wfifo_wr_data_q <= wfifo_wr_data_d;
      wr_trig_q       <= wr_trig_d;
      rd_trig_q       <= rd_trig_d;
      frame_err_q     <= frame_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    tmo_cnt_d       = tmo_cnt_q + 1'b1;
    wr_pend_d       = 1'b0;
    wfifo_wr_en_d   = 1'b0;
    wfifo_wr_data_d = wfifo_wr_data_q;
    wr_trig_d       = wr_pend_q;
    rd_trig_d       = 1'b0;
    frame_err_d     = 1'b0;

    if (bus.po_flag) begin
      tmo_cnt_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.po_flag && (bus.rx_data == HEADER)) begin
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        if (bus.po_flag) begin
          if (bus.rx_data == CMD_WR) begin
            state_d    = S_DATA;
            byte_cnt_d = 8'h00;
          end else if (bus.rx_data == CMD_RD) begin
            state_d   = S_IDLE;
            rd_trig_d = 1'b1;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end

      S_DATA: begin
        if (bus.po_flag) begin
          wfifo_wr_en_d   = 1'b1;
          wfifo_wr_data_d = bus.rx_data;
          byte_cnt_d      = byte_cnt_q + 8'h01;
          if (byte_cnt_q == WR_LAST) begin
            state_d   = S_IDLE;
            wr_pend_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      tmo_cnt_d = '0;
    end
  end

  assign bus.wfifo_wr_en   = wfifo_wr_en_q;
  assign bus.wfifo_wr_data = wfifo_wr_data_q;
  assign bus.wr_trig       = wr_trig_q;
  assign bus.rd_trig       = rd_trig_q;
  assign bus.frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: byte streams are replayed through a frame-level
// reference model that predicts every output pulse and the cycle it appears in.
module tb_uart_cmd_parser;
  localparam int TMO = 20;
  localparam int WRL = 4;
  localparam int K_PUSH = 0, K_WR = 1, K_RD = 2, K_ERR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .HEADER (8'h55),
    .CMD_WR (8'hAA),
    .CMD_RD (8'hBB),
    .WR_LEN (WRL),
    .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;
    logic [7:0]  data;
  } ev_t;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  ev_t        act_q[$];
  ev_t        exp_q[$];
  logic [7:0] sent_b[$];
  int         sent_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse is logged with the cycle in which it is visible.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wfifo_wr_en) act_q.push_back({32'(cyc), 2'(K_PUSH), bus.wfifo_wr_data});
      if (bus.wr_trig)     act_q.push_back({32'(cyc), 2'(K_WR), 8'h00});
      if (bus.rd_trig)     act_q.push_back({32'(cyc), 2'(K_RD), 8'h00});
      if (bus.frame_err)   act_q.push_back({32'(cyc), 2'(K_ERR), 8'h00});
    end
  end

  function automatic ev_t mk(input int c, input int k, input logic [7:0] d);
    return {32'(c), 2'(k), d};
  endfunction

  task automatic new_segment();
    act_q.delete();
    sent_b.delete();
    sent_c.delete();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bus.po_flag = 1'b0;
      bus.rx_data = 8'($urandom);
    end
    @(negedge clk);
    bus.po_flag = 1'b1;
    bus.rx_data = b;
    sent_b.push_back(b);
    sent_c.push_back(cyc);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send(bytes[i], int'($urandom_range(max_gap, 0)));
  endtask

  // Frame-level model: walks the sent bytes with their strobe cycles. Output
  // pulses land one cycle after the strobe (wr_trig two); a frame left open
  // for more than TMO cycles after its last byte aborts with frame_err.
  task automatic build_expected();
    string phase;
    int n, last, c;
    logic [7:0] b;
    exp_q.delete();
    phase = "hunt";
    n = 0;
    last = 0;
    foreach (sent_b[i]) begin
      c = sent_c[i];
      b = sent_b[i];
      if (phase != "hunt" && c > last + TMO) begin
        exp_q.push_back(mk(last + TMO + 1, K_ERR, 8'h00));
        phase = "hunt";
      end
      if (phase == "hunt") begin
        if (b == 8'h55) phase = "cmd";
      end else if (phase == "cmd") begin
        if (b == 8'hAA) begin
          phase = "payload";
          n = 0;
        end else begin
          exp_q.push_back(mk(c + 1, (b == 8'hBB) ? K_RD : K_ERR, 8'h00));
          phase = "hunt";
        end
      end else begin
        exp_q.push_back(mk(c + 1, K_PUSH, b));
        n++;
        if (n == WRL) begin
          exp_q.push_back(mk(c + 2, K_WR, 8'h00));
          phase = "hunt";
        end
      end
      last = c;
    end
    if (phase != "hunt") exp_q.push_back(mk(last + TMO + 1, K_ERR, 8'h00));
  endtask

  task automatic flush();
    int lim;
    @(negedge clk);
    bus.po_flag = 1'b0;
    lim = (sent_c.size() > 0) ? sent_c[sent_c.size()-1] + TMO + 4 : cyc + TMO + 4;
    while (cyc <= lim) @(negedge clk);
    build_expected();
  endtask

  task automatic test_reset();
    bus.po_flag = 1'b0;
    bus.rx_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.wfifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wfifo_wr_en); end
    total++; if (bus.wfifo_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", bus.wfifo_wr_data); end
    total++; if (bus.wr_trig !== 1'b0) begin bad++; $display("FAIL reset_wr_trig got=%b want=0", bus.wr_trig); end
    total++; if (bus.rd_trig !== 1'b0) begin bad++; $display("FAIL reset_rd_trig got=%b want=0", bus.rd_trig); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    new_segment();
    repeat (3) @(negedge clk);
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL reset_quiet got=%0d events want=0", act_q.size()); end
  endtask

  task automatic test_write();
    new_segment();
    send_seq('{8'h55, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44}, 3);
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL write_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL write_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_read_and_bad_cmd();
    new_segment();
    send_seq('{8'h55, 8'hBB, 8'h55, 8'hCC, 8'h55, 8'hBB}, 2);
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL rdcmd_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rdcmd_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    new_segment();
    send_seq('{8'h55, 8'hAA, 8'h11, 8'h22}, 1);
    send(8'h55, TMO + 5);
    send_seq('{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04}, 1);
    // Byte in the expiry cycle survives; one cycle later it is too late.
    send(8'h55, 2);
    send(8'hAA, TMO - 1);
    send(8'h0F, TMO - 1);
    send(8'hF0, TMO);
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL tmo_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL tmo_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_payload_literal();
    new_segment();
    send_seq('{8'h07, 8'h55, 8'h00, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA}, 2);
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL payload_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL payload_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    new_segment();
    send_seq('{8'h55, 8'hAA, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h55, 8'hBB, 8'h55, 8'h99,
               8'h55, 8'hAA, 8'hBB, 8'h55, 8'hAA, 8'h00, 8'h55, 8'hBB}, 0);
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    new_segment();
    send_seq('{8'h55, 8'hAA, 8'h11}, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.wfifo_wr_en !== 1'b0) begin bad++; $display("FAIL midrst_wr_en got=%b want=0", bus.wfifo_wr_en); end
    total++; if (bus.wfifo_wr_data !== 8'h00) begin bad++; $display("FAIL midrst_wr_data got=%h want=00", bus.wfifo_wr_data); end
    total++; if ({bus.wr_trig, bus.rd_trig, bus.frame_err} !== 3'b000) begin
      bad++; $display("FAIL midrst_trigs got=%b want=000", {bus.wr_trig, bus.rd_trig, bus.frame_err});
    end
    bus.po_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    new_segment();
    repeat (TMO + 5) @(negedge clk);
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL midrst_quiet got=%0d events want=0", act_q.size()); end
    new_segment();
    send_seq('{8'h55, 8'hBB}, 1);
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midrst_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap;
    new_segment();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(5, 0))
        0, 1: b = 8'h55;
        2:    b = 8'hAA;
        3:    b = 8'hBB;
        default: b = 8'($urandom);
      endcase
      gap = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TMO + 1, TMO - 1)) : int'($urandom_range(3, 0));
      send(b, gap);
    end
    flush();
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_ev[%0d] got=%h want=%h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_and_bad_cmd();
    test_timeout();
    test_payload_literal();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: HEADER, 8'h55, frame start byte.
REQ-002 Parameter: CMD_WR, 8'hAA, write command code.
REQ-003 Parameter: CMD_RD, 8'hBB, read command code.
REQ-004 Parameter: WR_LEN, 4, payload bytes per write frame (range 1..255).
REQ-005 Parameter: TIMEOUT, 50000, idle clk cycles between bytes before frame abort.
REQ-006 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-007 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-008 Port: rx_data  input  8  received byte from the UART receiver; valid only while po_flag=1.
REQ-009 Port: po_flag  input  1  one-cycle byte-valid strobe from the UART receiver.
REQ-010 Port: wfifo_wr_en  output  1  one-cycle push strobe to the SDRAM write-data FIFO.
REQ-011 Port: wfifo_wr_data  output  8  payload byte; valid while wfifo_wr_en=1.
REQ-012 Port: wr_trig  output  1  one-cycle pulse requesting an SDRAM write burst.
REQ-013 Port: rd_trig  output  1  one-cycle pulse requesting an SDRAM read burst.
REQ-014 Port: frame_err  output  1  one-cycle pulse on a bad command or timeout.

Function
REQ-015 The state machine SHALL have states S_IDLE, S_CMD and S_DATA; all outputs registered.
REQ-016 S_IDLE: po_flag with rx_data==HEADER -> S_CMD; any other byte ignored, no error.
REQ-017 S_CMD: po_flag with rx_data==CMD_WR -> S_DATA with byte counter cleared to 0.
REQ-018 S_CMD: po_flag with rx_data==CMD_RD -> S_IDLE and rd_trig=1 on the next cycle.
REQ-019 S_CMD: po_flag with any other byte -> S_IDLE and frame_err=1 on the next cycle.
REQ-020 S_DATA: each po_flag -> wfifo_wr_en=1 and wfifo_wr_data=rx_data on the next cycle; counter +1.
REQ-021 S_DATA: when the pushed byte is number WR_LEN -> S_IDLE; wr_trig=1 exactly one cycle after that last wfifo_wr_en.
REQ-022 In S_DATA, HEADER or command values SHALL be treated as plain payload.
REQ-023 Byte counter SHALL be 8 bits; never wraps, since the frame ends at WR_LEN.
REQ-024 Timeout counter SHALL clear on every po_flag and on entry to S_IDLE, and increment every cycle in S_CMD/S_DATA.
REQ-025 Counter reaching TIMEOUT-1 with no po_flag -> S_IDLE and frame_err=1 on the next cycle; bytes already pushed are not retracted; no wr_trig.
REQ-026 po_flag in the same cycle as timeout expiry: the byte wins; no error; counter clears.
REQ-027 po_flag on consecutive cycles SHALL each be processed without loss.
REQ-028 wr_trig, rd_trig and frame_err SHALL be mutually exclusive in any cycle.
REQ-029 Outputs wfifo_wr_en, wr_trig, rd_trig and frame_err SHALL be high for exactly one cycle per event.
REQ-030 FIFO fullness SHALL NOT be checked; upstream UART rate guarantees the FIFO drains.

Reset
REQ-031 rst_n=0 SHALL immediately force S_IDLE, clear both counters, and drive all outputs to 0, including wfifo_wr_data=8'h00.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; no trailing wr_trig or frame_err after release.
REQ-033 The first po_flag after reset release SHALL be parsed from S_IDLE.

Verification
REQ-034 Bytes 55 AA 11 22 33 44 -> four wfifo_wr_en pulses with data 11,22,33,44; wr_trig one cycle after the fourth; no frame_err.
REQ-035 Bytes 55 BB -> rd_trig one cycle after the BB strobe; no wfifo_wr_en.
REQ-036 Bytes 55 CC -> frame_err one cycle after the CC strobe; a following 55 BB still yields rd_trig.
REQ-037 Bytes 55 AA 11 22, then silence for TIMEOUT cycles -> two pushes, frame_err, no wr_trig; next 55 AA frame parsed cleanly.
REQ-038 Bytes 07 55 00 AA, with 55 AA 55 AA 55 AA as a payload test -> leading 07 ignored, 00 gives frame_err; payload 55 AA 55 AA pushed verbatim with wr_trig.
REQ-039 rst_n pulsed low after 55 AA 11 -> all outputs 0 during reset; no wr_trig after release; fresh 55 BB gives rd_trig.
